// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types and constants for the ALU sequencer: instruction field
//   positions, datapath widths, the opcode enum and the controller state enum.
//   No ports (package).
package alu_seq_pkg;

    localparam int OP_WIDTH    = 3;
    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 9;

    // Instruction layout: op [8:6], ra [5:3], rb [2:0]
    localparam int OP_MSB = 8;
    localparam int RA_LSB = 3;
    localparam int RB_LSB = 0;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_ADD  = 3'd2,
        OP_SRL  = 3'd3,
        OP_SRA  = 3'd4,
        OP_BEQ  = 3'd5,
        OP_MEM  = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

endpackage

// File: rtl/alu_sequencer_instr_decode.sv
// instr_decode
//   Purely combinational split of the instruction register into its fields
//   and the class flags the sequencer branches on.
// Ports:
//   ir            in  instruction register
//   op            out opcode field
//   ra, rb        out register address fields
//   is_alu        out ops 0..4 (register writeback)
//   is_branch     out BEQ
//   is_mem        out load/store
//   is_store      out MEM with rb[2] set
//   is_halt       out HALT
//   writes_carry  out ADD/SRL/SRA (ops that produce a carry-out)
module instr_decode
    import alu_seq_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] ir,
    output logic [OP_WIDTH-1:0]    op,
    output logic [2:0]             ra,
    output logic [2:0]             rb,
    output logic                   is_alu,
    output logic                   is_branch,
    output logic                   is_mem,
    output logic                   is_store,
    output logic                   is_halt,
    output logic                   writes_carry
);

    opcode_t opc;

    assign opc          = opcode_t'(ir[OP_MSB -: OP_WIDTH]);
    assign op           = opc;
    assign ra           = ir[RA_LSB +: 3];
    assign rb           = ir[RB_LSB +: 3];
    assign is_alu       = opc inside {OP_AND, OP_OR, OP_ADD, OP_SRL, OP_SRA};
    assign is_branch    = (opc == OP_BEQ);
    assign is_mem       = (opc == OP_MEM);
    // rb[1:0] carry no meaning for memory ops; only rb[2] selects direction
    assign is_store     = is_mem && rb[2];
    assign is_halt      = (opc == OP_HALT);
    assign writes_carry = opc inside {OP_ADD, OP_SRL, OP_SRA};

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle fetch/decode/execute controller for the 8-bit ALU.
//   Fetches over a req/valid handshake, issues ALU opcode and register read
//   addresses, sequences register/carry/data-memory writeback and steps the PC.
//   Optional feature macro: ALU_SEQ_CARRY_WB_EN (carry write strobe in WB for
//   ADD/SRL/SRA; when undefined car_we stays 0).
// Ports:
//   clk, reset (async, active-high), start (level, honoured in IDLE/HALT)
//   imem_req/imem_addr out, imem_valid/imem_instr in  : instruction fetch
//   alu_op, ra_addr, rb_addr out; alu_zero, alu_jump in : ALU interface
//   rf_we, car_we out                                  : writeback strobes
//   dmem_req, dmem_we out; dmem_ack in                 : data memory
//   pc, halted out                                     : architectural status
//   zero_q out                                         : alu_zero captured in WB (debug)
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    output logic [OP_WIDTH-1:0]    alu_op,
    output logic [2:0]             ra_addr,
    output logic [2:0]             rb_addr,
    input  logic                   alu_zero,
    input  logic                   alu_jump,
    output logic                   rf_we,
    output logic                   car_we,
    output logic                   dmem_req,
    output logic                   dmem_we,
    input  logic                   dmem_ack,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   halted,
    output logic                   zero_q
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_TWO = PC_WIDTH'(2);

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   carry_d;

    logic [OP_WIDTH-1:0]    dec_op;
    logic                   dec_alu, dec_branch, dec_mem, dec_store, dec_halt, dec_carry;

    instr_decode u_decode (
        .ir           (ir_q),
        .op           (dec_op),
        .ra           (ra_addr),
        .rb           (rb_addr),
        .is_alu       (dec_alu),
        .is_branch    (dec_branch),
        .is_mem       (dec_mem),
        .is_store     (dec_store),
        .is_halt      (dec_halt),
        .writes_carry (dec_carry)
    );

    // The register addresses are bit slices of IR, so they are register outputs
    // that appear in DECODE and hold until the next fetch is accepted.
    assign imem_addr = pc_q;
    assign pc        = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (dec_branch) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + (alu_jump ? PC_TWO : PC_ONE);
                end else if (dec_mem) begin
                    state_d = S_MEM;
                end else if (dec_alu) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (dec_store) begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_ONE;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_ONE;
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ALU_SEQ_CARRY_WB_EN
    assign carry_d = (state_d == S_WB) && dec_carry;
`else
    logic carry_unused;
    assign carry_unused = dec_carry;
    assign carry_d      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs are registered from the next state so each strobe is high for
    // exactly the cycles the FSM spends in the matching state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            car_we   <= 1'b0;
            halted   <= 1'b0;
            alu_op   <= '0;
            zero_q   <= 1'b0;
        end else begin
            imem_req <= (state_d == S_FETCH);
            dmem_req <= (state_d == S_MEM);
            dmem_we  <= (state_d == S_MEM) && dec_store;
            rf_we    <= (state_d == S_WB);
            car_we   <= carry_d;
            halted   <= (state_d == S_HALT);
            alu_op   <= (state_d inside {S_EXEC, S_MEM, S_WB}) ? dec_op : '0;
            if (state_q == S_WB) zero_q <= alu_zero;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed bench for alu_sequencer. Expected writebacks are queued when an
//   instruction is fetched and popped by a monitor whenever rf_we is seen.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [8:0] imem_instr;
    logic [2:0] alu_op;
    logic [2:0] ra_addr;
    logic [2:0] rb_addr;
    logic       alu_zero;
    logic       alu_jump;
    logic       rf_we;
    logic       car_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic [7:0] pc;
    logic       halted;
    logic       zero_q;

    typedef struct {
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       car;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_pc;

    alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_instr (imem_instr),
        .alu_op     (alu_op),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .alu_zero   (alu_zero),
        .alu_jump   (alu_jump),
        .rf_we      (rf_we),
        .car_we     (car_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .halted     (halted),
        .zero_q     (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic car_exp(input logic [2:0] op);
`ifdef ALU_SEQ_CARRY_WB_EN
        return (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction after 'waits' idle cycles of an outstanding request.
    // Returns one cycle after acceptance (DUT in DECODE).
    task automatic fetch(input logic [8:0] instr, input int waits);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("fetch_req", imem_req, 1'b1);
        for (int i = 0; i < waits; i++) begin
            tick();
            check("fetch_hold", imem_req, 1'b1);
        end
        imem_valid = 1'b1;
        imem_instr = instr;
        tick();
        imem_valid = 1'b0;
        imem_instr = '0;
        check("fetch_drop", imem_req, 1'b0);
    endtask

    task automatic run_alu(input logic [8:0] instr, input int waits, input logic zero);
        check("alu_addr", imem_addr, exp_pc);
        fetch(instr, waits);
        sb.push_back('{instr[8:6], instr[5:3], instr[2:0], car_exp(instr[8:6])});
        check("dec_ra", ra_addr, instr[5:3]);
        check("dec_rb", rb_addr, instr[2:0]);
        tick();
        check("exec_op", alu_op, instr[8:6]);
        check("exec_no_we", rf_we, 1'b0);
        alu_zero = zero;
        tick();
        check("wb_rf_we", rf_we, 1'b1);
        check("wb_car_we", car_we, car_exp(instr[8:6]));
        tick();
        alu_zero = 1'b0;
        check("wb_one_cycle", rf_we, 1'b0);
        check("zero_q", zero_q, zero);
        exp_pc = exp_pc + 8'd1;
        check("alu_pc_next", pc, exp_pc);
    endtask

    task automatic run_beq(input logic [8:0] instr, input logic jump);
        check("beq_addr", imem_addr, exp_pc);
        fetch(instr, 0);
        tick();
        check("beq_op", alu_op, 3'd5);
        alu_jump = jump;
        tick();
        alu_jump = 1'b0;
        exp_pc = exp_pc + (jump ? 8'd2 : 8'd1);
        check("beq_pc", pc, exp_pc);
        check("beq_next_addr", imem_addr, exp_pc);
        check("beq_refetch", imem_req, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (sb.size() == 0) begin
                check("rf_we_unexpected", rf_we, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_op", alu_op, mon_e.op);
                check("sb_ra", ra_addr, mon_e.ra);
                check("sb_rb", rb_addr, mon_e.rb);
                check("sb_car", car_we, mon_e.car);
            end
        end
        if (!reset && !rf_we && car_we) check("car_we_stray", car_we, 1'b0);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        imem_valid = 1'b0;
        imem_instr = '0;
        alu_zero   = 1'b0;
        alu_jump   = 1'b0;
        dmem_ack   = 1'b0;
        exp_pc     = 8'h00;
        tick();
        tick();
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_pc", pc, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_strobes", {rf_we, car_we, dmem_req, dmem_we}, 4'b0000);
        check("rst_alu_op", alu_op, 3'd0);
        check("rst_regs", {ra_addr, rb_addr}, 6'd0);
        reset = 1'b0;
        tick();
        check("idle_no_req", imem_req, 1'b0);

        // Reset while a fetch is outstanding
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fetch_start", imem_req, 1'b1);
        tick();
        check("fetch_wait", imem_req, 1'b1);
        reset = 1'b1;
        tick();
        check("midrst_req", imem_req, 1'b0);
        check("midrst_pc", pc, 8'h00);
        reset = 1'b0;
        tick();
        check("midrst_idle", imem_req, 1'b0);

        // ADD ra=2 rb=5 with three wait cycles, then a few more ALU ops to PC=4
        start = 1'b1;
        tick();
        start = 1'b0;
        run_alu(9'h095, 3, 1'b1);
        run_alu(9'h04A, 1, 1'b0);
        run_alu(9'h01C, 0, 1'b0);
        run_alu(9'h0FE, 2, 1'b1);

        // BEQ taken at 4, not taken at 6
        run_beq(9'h151, 1'b1);
        check("beq_taken_6", imem_addr, 8'h06);
        run_beq(9'h151, 1'b0);
        check("beq_not_taken_7", imem_addr, 8'h07);

        // Store with ack after two extra cycles
        fetch(9'h18C, 0);
        tick();
        check("st_op", alu_op, 3'd6);
        tick();
        check("st_req1", dmem_req, 1'b1);
        check("st_we", dmem_we, 1'b1);
        tick();
        check("st_req2", dmem_req, 1'b1);
        tick();
        check("st_req3", dmem_req, 1'b1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("st_req_drop", dmem_req, 1'b0);
        check("st_we_drop", dmem_we, 1'b0);
        exp_pc = exp_pc + 8'd1;
        check("st_pc", pc, exp_pc);

        // Load ra=2 rb=3 with immediate ack
        fetch(9'h193, 0);
        sb.push_back('{3'd6, 3'd2, 3'd3, 1'b0});
        tick();
        tick();
        check("ld_req", dmem_req, 1'b1);
        check("ld_we", dmem_we, 1'b0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("ld_wb", rf_we, 1'b1);
        check("ld_req_drop", dmem_req, 1'b0);
        tick();
        exp_pc = exp_pc + 8'd1;
        check("ld_pc", pc, exp_pc);

        // Walk up to 0xFF, branch across the wrap, walk back, ALU op across the wrap
        for (int i = 0; i < 123; i++) run_beq(9'h151, 1'b1);
        check("at_ff_1", pc, 8'hFF);
        run_beq(9'h151, 1'b1);
        check("wrap_beq", pc, 8'h01);
        for (int i = 0; i < 127; i++) run_beq(9'h151, 1'b1);
        check("at_ff_2", pc, 8'hFF);
        run_alu(9'h12B, 0, 1'b0);
        check("wrap_alu", pc, 8'h00);

        // HALT, then restart
        fetch(9'h1C0, 1);
        tick();
        check("halt_flag", halted, 1'b1);
        check("halt_no_req", imem_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_stay", {halted, imem_req}, 2'b10);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_halted", halted, 1'b0);
        check("restart_addr", imem_addr, 8'h00);
        check("restart_req", imem_req, 1'b1);
        exp_pc = 8'h00;
        run_alu(9'h095, 0, 1'b1);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
